alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational ALU.
- WIDTH-bit operands and 8 operations; legacy 2-bit encodings are kept as the low half of a 3-bit select.
- Two-stage registered pipeline with valid/ready handshakes on input and output. Produces result plus status flags.
- Sits between the operand register file and the writeback path.

Parameters:
- WIDTH, 8, operand/result width; power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (shift amount = b[SHW-1:0]).
- sel  in  3  operation select.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  operation result.
- flags  out  4  {ovf, neg, carry, zero}.

Behaviour:
- Reset, asynchronous on rst_n low:
  - Both stage valid bits clear.
  - out_valid=0, result=0, flags=0.
  - in_ready=1 once rst_n is high.
- Reset mid-operation discards all in-flight beats; nothing is replayed.
- Handshakes:
  - Beat accepted when in_valid & in_ready.
  - Result consumed when out_valid & out_ready.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - During stall both stages hold; result and flags stay stable.
- Stage 1 registers a, b, sel and a valid bit on acceptance.
  - A bubble (valid=0) is loaded when not stalled and nothing is accepted.
- Stage 2 computes from stage-1 registers and registers result, flags and out_valid when not stalled.
- Latency: accept at edge N, out_valid high after edge N+2. Throughput one beat/cycle with out_ready held high.
- Operations (sel):
  - 000 ADD: a+b.
  - 001 AND.
  - 010 OR.
  - 011 XOR.
  - 100 SUB: a-b.
  - 101 SHL: logical left by b[SHW-1:0].
  - 110 SHR: logical right by b[SHW-1:0].
  - 111 SLT: signed a<b gives 1, else 0, zero-extended.
- Width rules: all arithmetic modulo 2^WIDTH. Upper bits of b are ignored for shifts, so an amount ≥WIDTH wraps modulo WIDTH.
- Flags:
  - zero = (result==0), all ops.
  - neg = result[WIDTH-1], all ops.
  - carry: ADD carry-out; SUB borrow (a<b unsigned); 0 otherwise.
  - ovf: signed overflow for ADD/SUB only; 0 otherwise.
- Flags are computed on the final (possibly saturated) result, except ovf and carry, which reflect the unsaturated operation.
- Simultaneous events:
  - Accept and consume in the same cycle is legal; the pipeline advances.
  - out_ready rising while stalled releases on that edge; in_ready rises in the same cycle.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined: ADD/SUB saturate signed on overflow: positive overflow gives 0x7F.. (max), negative overflow gives 0x80.. (min). ovf is still asserted.
- Undefined: ADD/SUB wrap modulo 2^WIDTH.
- All other ops are identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams (OP_ADD..OP_SLT, 3-bit);
  - flag bit indices (FLG_ZERO=0, FLG_CARRY=1, FLG_NEG=2, FLG_OVF=3).
- Sub-module alu_core: purely combinational, parametrised by WIDTH, maps (a, b, sel) to (result, flags), and contains the saturation logic.
- alu_pipe holds only the pipeline registers, valid bits and stall logic.

Test Plan (WIDTH=8):
- ADD a=0xFF b=0x01, out_ready=1 → after 2 cycles result=0x00, flags zero=1 carry=1 ovf=0 neg=0.
- SUB a=0x80 b=0x01 → result=0x7F, ovf=1, carry=0. With ALU_PIPE_SAT_EN: result=0x80, ovf=1, neg=1.
- SHL a=0x81 b=0x09 → result=0x02 (amount 1). SHR a=0x81 b=0x07 → 0x01. SLT a=0xFE b=0x01 → 0x01.
- Backpressure: out_ready=0, drive 3 back-to-back beats → 2 accepted, in_ready=0 from cycle 2. Raise out_ready → all 3 results delivered in order, none lost or duplicated.
- Streaming: 16 random beats with out_ready=1 → one result per cycle after 2-cycle fill, matching the reference model.
- Assert rst_n low with 2 beats in flight → out_valid=0, result=0, flags=0 immediately (async). After release, no stale beat appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-codes and flag bit positions for the pipelined ALU.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int FLAG_W    = 4;
    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_NEG   = 2;
    localparam int FLG_OVF   = 3;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, sel) -> (result, flags).
// Build option ALU_PIPE_SAT_EN makes ADD/SUB saturate signed on overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        sel,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] res_raw;
    logic [WIDTH-1:0] res_fin;
    logic             carry;
    logic             ovf;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign shamt   = b[SHW-1:0];
    // On any ADD/SUB overflow the sign of a tells which rail was crossed.
    assign sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        res_raw = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (sel)
            OP_ADD: begin
                res_raw = sum[WIDTH-1:0];
                carry   = sum[WIDTH];
                ovf     = add_ovf;
            end
            OP_AND: res_raw = a & b;
            OP_OR:  res_raw = a | b;
            OP_XOR: res_raw = a ^ b;
            OP_SUB: begin
                res_raw = diff[WIDTH-1:0];
                carry   = diff[WIDTH];
                ovf     = sub_ovf;
            end
            OP_SHL: res_raw = a << shamt;
            OP_SHR: res_raw = a >> shamt;
            default: res_raw = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        endcase
    end

    always_comb begin
`ifdef ALU_PIPE_SAT_EN
        res_fin = ovf ? sat_val : res_raw;
`else
        res_fin = res_raw;
`endif
    end

    always_comb begin
        flags            = '0;
        flags[FLG_ZERO]  = (res_fin == '0);
        flags[FLG_CARRY] = carry;
        flags[FLG_NEG]   = res_fin[WIDTH-1];
        flags[FLG_OVF]   = ovf;
    end

    assign result = res_fin;
endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Build option ALU_PIPE_SAT_EN (inside alu_core) selects saturating ADD/SUB.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);
    // Handshake: a beat moves on an edge where valid & ready are both high;
    // ready never depends on valid, and a stalled output holds result/flags.
    logic              stall;
    logic              s1_valid;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic [2:0]        s1_sel;
    logic [WIDTH-1:0]  core_result;
    logic [FLAG_W-1:0] core_flags;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .sel    (s1_sel),
        .result (core_result),
        .flags  (core_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sel    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (!stall) begin
            // in_ready is high here, so in_valid alone decides beat vs bubble.
            s1_valid  <= in_valid;
            s1_a      <= a;
            s1_b      <= b;
            s1_sel    <= sel;
            out_valid <= s1_valid;
            result    <= core_result;
            flags     <= core_flags;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): ops, flags, latency, backpressure,
// streaming and asynchronous reset; expected results are {flags, result}.
module tb_alu_pipe;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;

    int vectors;
    int miscompares;
    int max_run;
    int run_len;
    int consumed;
    logic [11:0] exp_q[$];

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // independent integer reference: returns {ovf, neg, carry, zero, result}
    function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic [2:0] ms);
        int ua, ub, sa, sb, sv, r;
        bit c, v;
        logic [7:0] rr;
        ua = ma; ub = mb;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        r = 0; sv = 0; c = 0; v = 0;
        case (ms)
            3'd0: begin r = (ua + ub) % 256; c = (ua + ub) > 255; sv = sa + sb; end
            3'd1: r = ua & ub;
            3'd2: r = ua | ub;
            3'd3: r = ua ^ ub;
            3'd4: begin r = (ua - ub + 256) % 256; c = ua < ub; sv = sa - sb; end
            3'd5: r = (ua << (ub % 8)) % 256;
            3'd6: r = ua >> (ub % 8);
            default: r = (sa < sb) ? 1 : 0;
        endcase
        v = (ms == 3'd0 || ms == 3'd4) && (sv > 127 || sv < -128);
`ifdef ALU_PIPE_SAT_EN
        if (v) r = (sv > 127) ? 127 : 128;
`endif
        rr = r[7:0];
        return {v, (r > 127), c, (r == 0), rr};
    endfunction

    // driver: hold the beat until accepted, bounded
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] ts,
                        input logic [11:0] e);
        bit acc;
        acc = 1'b0;
        a = ta; b = tb; sel = ts; in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            if (acc) exp_q.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; max_run = 0; run_len = 0; consumed = 0;
        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;

        // scoreboard
        fork
            forever begin
                @(negedge clk);
                if (out_valid === 1'b1) run_len++; else run_len = 0;
                if (run_len > max_run) max_run = run_len;
                if (rst_n && out_valid === 1'b1 && out_ready) begin
                    consumed++;
                    if (exp_q.size() == 0) check("sb_extra_beat", {flags, result}, 12'hFFF ^ {flags, result});
                    else check("sb_result", {flags, result}, exp_q.pop_front());
                end
            end
        join_none

        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // latency: ADD FF+01
        a = 8'hFF; b = 8'h01; sel = 3'd0; in_valid = 1'b1;
        exp_q.push_back(12'h300);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_edge1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge2_valid", out_valid, 1);
        check("add_ff_01", {flags, result}, 12'h300);
        wait_drain();

        // directed ops, back to back
`ifdef ALU_PIPE_SAT_EN
        send(8'h80, 8'h01, 3'd4, 12'hC80);
        send(8'h7F, 8'h01, 3'd0, 12'h87F);
`else
        send(8'h80, 8'h01, 3'd4, 12'h87F);
        send(8'h7F, 8'h01, 3'd0, 12'hC80);
`endif
        send(8'h81, 8'h09, 3'd5, 12'h002);
        send(8'h81, 8'h07, 3'd6, 12'h001);
        send(8'h80, 8'h0F, 3'd6, 12'h001);
        send(8'hFE, 8'h01, 3'd7, 12'h001);
        send(8'h01, 8'hFE, 3'd7, 12'h100);
        send(8'hF0, 8'h3C, 3'd1, 12'h030);
        send(8'h80, 8'h01, 3'd2, 12'h481);
        send(8'hAA, 8'hAA, 3'd3, 12'h100);
        send(8'h00, 8'h01, 3'd4, 12'h6FF);
        wait_drain();

        // backpressure: three beats against a stalled output
        out_ready = 1'b0;
        a = 8'h01; b = 8'h02; sel = 3'd0; in_valid = 1'b1; exp_q.push_back(12'h003);
        check("bp_ready_c0", in_ready, 1);
        @(posedge clk); #1;
        a = 8'h0F; b = 8'hF0; sel = 3'd3; exp_q.push_back(12'h4FF);
        check("bp_ready_c1", in_ready, 1);
        @(posedge clk); #1;
        a = 8'h0F; b = 8'hF0; sel = 3'd1; exp_q.push_back(12'h100);
        check("bp_ready_c2", in_ready, 0);
        @(posedge clk); #1;
        check("bp_ready_c3", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", {flags, result}, 12'h003);
        consumed = 0;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
        check("bp_consumed", consumed, 3);

        // streaming with model
        max_run = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] ra, rb;
            logic [2:0] rs;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 3'($urandom_range(0, 7));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        wait_drain();
        check("stream_run", max_run, 16);

        // async reset with two beats in flight
        a = 8'h12; b = 8'h34; sel = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h55; b = 8'h0F; sel = 3'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_flags", flags, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", out_valid, 0);
        end
        check("post_rst_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
